// File: rtl/parity_frame_engine.sv
// Frame parity engine: accumulates parity over a valid/ready word stream,
// emits one even/odd parity result per frame and counts checked errors.
module parity_frame_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             chk_en,
  input  logic             chk_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state;
  logic             acc;
  logic             mode_r;
  logic             first;
  logic [CNT_W-1:0] frame_cnt;

  logic             beat;
  logic             word_par;
  logic             acc_nxt;
  logic             mode_eff;
  logic             par_nxt;
  logic             err_nxt;
  logic             err_inc;
  logic [CNT_W-1:0] cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A fresh error survives a coincident clear, leaving the count at one.
  function automatic logic [CNT_W-1:0] err_update(input logic [CNT_W-1:0] cur,
                                                  input logic inc,
                                                  input logic clr);
    if (clr)
      return inc ? CNT_W'(1) : '0;
    else if (inc)
      return sat_inc(cur);
    else
      return cur;
  endfunction

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);

  assign beat     = in_valid & (state == ACC);
  assign word_par = ^in_data;
  assign acc_nxt  = acc ^ word_par;
  assign mode_eff = first ? odd_mode : mode_r;
  assign par_nxt  = acc_nxt ^ mode_eff;
  assign err_nxt  = chk_en & (chk_bit != par_nxt);
  assign err_inc  = beat & in_last & err_nxt;
  assign cnt_nxt  = sat_inc(frame_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACC;
      acc        <= 1'b0;
      mode_r     <= 1'b0;
      first      <= 1'b1;
      frame_cnt  <= '0;
      out_parity <= 1'b0;
      out_error  <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      err_count <= err_update(err_count, err_inc, err_clr);
      case (state)
        ACC: begin
          if (in_valid) begin
            acc       <= acc_nxt;
            frame_cnt <= cnt_nxt;
            mode_r    <= mode_eff;
            first     <= 1'b0;
            if (in_last) begin
              out_parity <= par_nxt;
              out_error  <= err_nxt;
              word_count <= cnt_nxt;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          // Retiring the result only rearms the accumulator; no beat is taken here.
          if (out_ready) begin
            acc       <= 1'b0;
            frame_cnt <= '0;
            first     <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_engine.sv
// Bench for parity_frame_engine: three instances (8/8, 3/8, 8/2) share one
// stimulus stream and are compared with a frame-level parity model.
module tb_parity_frame_engine;

  logic       clk = 1'b0;
  logic       rst, odd_mode, in_valid, in_last, chk_en, chk_bit, out_ready, err_clr;
  logic [7:0] in_data;

  logic       ir8, ov8, op8, oe8;
  logic [7:0] wc8, ec8;
  logic       ir3, ov3, op3, oe3;
  logic [7:0] wc3, ec3;
  logic       ir2, ov2, op2, oe2;
  logic [1:0] wc2, ec2;

  parity_frame_engine #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid), .in_ready(ir8),
    .in_data(in_data), .in_last(in_last), .chk_en(chk_en), .chk_bit(chk_bit),
    .out_valid(ov8), .out_ready(out_ready), .out_parity(op8), .out_error(oe8),
    .word_count(wc8), .err_count(ec8), .err_clr(err_clr));

  parity_frame_engine #(.WIDTH(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid), .in_ready(ir3),
    .in_data(in_data[2:0]), .in_last(in_last), .chk_en(chk_en), .chk_bit(chk_bit),
    .out_valid(ov3), .out_ready(out_ready), .out_parity(op3), .out_error(oe3),
    .word_count(wc3), .err_count(ec3), .err_clr(err_clr));

  parity_frame_engine #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .odd_mode(odd_mode), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .in_last(in_last), .chk_en(chk_en), .chk_bit(chk_bit),
    .out_valid(ov2), .out_ready(out_ready), .out_parity(op2), .out_error(oe2),
    .word_count(wc2), .err_count(ec2), .err_clr(err_clr));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fq[$];
  bit e_par8, e_par3, e_err8, e_err3;
  int e_wc8, e_wc2, e_ec8, e_ec3, e_ec2;

  typedef struct {
    logic [31:0] words;
    int          n;
    bit          om, ce, cb, clr;
    int          hold;
    bit          exp_par, exp_err;
    int          exp_wc, exp_ec;
  } vec_t;

  vec_t tv[5];
  bit   orig[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ec_upd(input int cur, input bit e, input bit clr, input int mx);
    if (clr) return e ? 1 : 0;
    if (e) return (cur < mx) ? cur + 1 : mx;
    return cur;
  endfunction

  task automatic model_frame(input bit om, input bit ce, input bit cb, input bit clr);
    int ones8, ones3, n;
    ones8 = 0;
    ones3 = 0;
    foreach (fq[i]) begin
      ones8 += $countones(fq[i]);
      ones3 += $countones(fq[i][2:0]);
    end
    n = fq.size();
    e_par8 = bit'(ones8 % 2) ^ om;
    e_par3 = bit'(ones3 % 2) ^ om;
    e_err8 = ce && (cb != e_par8);
    e_err3 = ce && (cb != e_par3);
    e_wc8  = (n > 255) ? 255 : n;
    e_wc2  = (n > 3) ? 3 : n;
    e_ec8  = ec_upd(e_ec8, e_err8, clr, 255);
    e_ec3  = ec_upd(e_ec3, e_err3, clr, 255);
    e_ec2  = ec_upd(e_ec2, e_err8, clr, 3);
  endtask

  task automatic check_outputs();
    check("out_valid8", 32'(ov8), 1);
    check("out_valid3", 32'(ov3), 1);
    check("out_valid2", 32'(ov2), 1);
    check("parity8", 32'(op8), 32'(e_par8));
    check("parity3", 32'(op3), 32'(e_par3));
    check("parity2", 32'(op2), 32'(e_par8));
    check("error8", 32'(oe8), 32'(e_err8));
    check("error3", 32'(oe3), 32'(e_err3));
    check("error2", 32'(oe2), 32'(e_err8));
    check("wcount8", 32'(wc8), e_wc8);
    check("wcount3", 32'(wc3), e_wc8);
    check("wcount2", 32'(wc2), e_wc2);
    check("ecount8", 32'(ec8), e_ec8);
    check("ecount3", 32'(ec3), e_ec3);
    check("ecount2", 32'(ec2), e_ec2);
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the last beat.
  task automatic send_frame(input bit om, input bit ce, input bit cb, input bit clr);
    int n;
    n = fq.size();
    for (int i = 0; i < n; i++) begin
      check("in_ready_beat", 32'(ir8), 1);
      in_valid = 1'b1;
      in_data  = fq[i];
      in_last  = (i == n - 1);
      odd_mode = (i == 0) ? om : ~om;
      chk_en   = (i == n - 1) ? ce : 1'($urandom);
      chk_bit  = (i == n - 1) ? cb : 1'($urandom);
      err_clr  = (i == n - 1) ? clr : 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_en   = 1'b0;
    chk_bit  = 1'b0;
    err_clr  = 1'b0;
    model_frame(om, ce, cb, clr);
    check_outputs();
  endtask

  task automatic retire(input int hold);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      odd_mode = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready", 32'(ir8), 0);
      check_outputs();
    end
    out_ready = 1'b1;
    in_valid  = (hold > 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("retire_valid8", 32'(ov8), 0);
    check("retire_valid3", 32'(ov3), 0);
    check("retire_valid2", 32'(ov2), 0);
    check("retire_ready8", 32'(ir8), 1);
    check("retire_ready3", 32'(ir3), 1);
    check("retire_ready2", 32'(ir2), 1);
  endtask

  initial begin
    logic [31:0] wv;
    rst = 1'b1; odd_mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    chk_en = 1'b0; chk_bit = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    e_ec8 = 0; e_ec3 = 0; e_ec2 = 0;

    tv[0] = '{32'h0301FF00, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 0};
    tv[1] = '{32'h0301FF00, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 3, 0};
    tv[2] = '{32'hA5000000, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1, 1};
    tv[3] = '{32'hA5000000, 1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1, 1};
    tv[4] = '{32'hA5000000, 1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1, 1};
    orig = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    #2;
    check("rst_in_ready", 32'(ir8), 1);
    check("rst_out_valid", 32'(ov8), 0);
    check("rst_parity", 32'(op8), 0);
    check("rst_error", 32'(oe8), 0);
    check("rst_wcount", 32'(wc8), 0);
    check("rst_ecount", 32'(ec8), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed frames with hand-derived expectations
    for (int i = 0; i < 5; i++) begin
      fq.delete();
      wv = tv[i].words;
      for (int k = 0; k < tv[i].n; k++) fq.push_back(wv[31 - 8*k -: 8]);
      send_frame(tv[i].om, tv[i].ce, tv[i].cb, tv[i].clr);
      check("tbl_parity", 32'(op8), 32'(tv[i].exp_par));
      check("tbl_error", 32'(oe8), 32'(tv[i].exp_err));
      check("tbl_wcount", 32'(wc8), tv[i].exp_wc);
      check("tbl_ecount", 32'(ec8), tv[i].exp_ec);
      retire(tv[i].hold);
    end

    // 3-bit odd parity against the original combinational function
    for (int w = 0; w < 8; w++) begin
      fq.delete();
      fq.push_back({5'($urandom), 3'(w)});
      send_frame(1'b1, 1'b0, 1'b0, 1'b0);
      check("orig3", 32'(op3), 32'(orig[w]));
      retire(0);
    end

    // Standalone clear, then counter saturation on the narrow instance
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    e_ec8 = 0; e_ec3 = 0; e_ec2 = 0;
    check("clr_ecount8", 32'(ec8), 0);
    check("clr_ecount2", 32'(ec2), 0);
    check("clr_ecount3", 32'(ec3), 0);
    fq.delete();
    for (int k = 0; k < 5; k++) fq.push_back(8'($urandom));
    send_frame(1'($urandom), 1'b0, 1'b0, 1'b0);
    check("sat_wcount2", 32'(wc2), 3);
    check("sat_wcount8", 32'(wc8), 5);
    retire(1);
    for (int k = 0; k < 5; k++) begin
      fq.delete();
      fq.push_back(8'h00);
      send_frame(1'b0, 1'b1, 1'b1, 1'b0);
      check("sat_ecount2", 32'(ec2), (k < 3) ? k + 1 : 3);
      retire(0);
    end

    // Reset in the middle of a frame
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0; odd_mode = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(ir8), 1);
    check("mid_rst_out_valid", 32'(ov8), 0);
    check("mid_rst_ecount8", 32'(ec8), 0);
    check("mid_rst_ecount2", 32'(ec2), 0);
    check("mid_rst_wcount", 32'(wc8), 0);
    @(negedge clk);
    rst = 1'b0;
    e_ec8 = 0; e_ec3 = 0; e_ec2 = 0;
    fq.delete();
    fq.push_back(8'h01);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_parity", 32'(op8), 1);
    check("post_rst_wcount", 32'(wc8), 1);
    retire(0);

    // Randomized frames against the model
    for (int f = 0; f < 40; f++) begin
      fq.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) fq.push_back(8'($urandom));
      send_frame(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      retire(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_frame_engine.md
Name: parity_frame_engine

Overview:
- Sequential, parametrised successor to the team's 3-input combinational parity function.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and accumulates parity across a frame terminated by in_last.
- Emits one parity result per frame (even or odd mode), with optional check against a received parity bit.
- Keeps a saturating error counter; sits between a byte/word source and a link-integrity monitor.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CNT_W, 8, width of err_count and word_count (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
odd_mode  input  1  0: even parity, 1: odd parity; sampled on first accepted word of a frame
in_valid  input  1  source has a word
in_ready  output  1  engine can accept a word
in_data  input  WIDTH  data word
in_last  input  1  word is the final word of the frame
chk_en  input  1  compare chk_bit on the last beat; sampled with in_last
chk_bit  input  1  received parity bit; sampled with in_last
out_valid  output  1  frame result available
out_ready  input  1  sink accepts result
out_parity  output  1  generated parity bit for the frame
out_error  output  1  1 = chk_en was set and chk_bit != out_parity
word_count  output  CNT_W  words in the frame, saturating at 2^CNT_W-1
err_count  output  CNT_W  total frames flagged in error, saturating
err_clr  input  1  synchronous clear of err_count

Behaviour:
- Reset (async, immediate): state=ACC, accumulator=0, frame-mode register=0, first-word flag=1.
  - All outputs 0 except in_ready=1: out_valid=0, out_parity=0, out_error=0, word_count=0, err_count=0.
- Beat accepted: in_valid & in_ready at a rising edge.
- Parity definition: P = XOR of all bits of all words in the frame. EVEN mode: out_parity = P. ODD mode: out_parity = ~P. Total ones including the parity bit is then even or odd respectively.
- FSM states ACC and DONE:
  - ACC:
    - in_ready=1, out_valid=0.
    - Each accepted beat: acc <= acc ^ (^in_data); frame count increments (saturating).
    - First beat of a frame latches odd_mode and clears the first-word flag.
    - Accepted beat with in_last=1:
      - Compute the final result including that word.
      - Load out_parity, word_count, and out_error = chk_en & (chk_bit != out_parity).
      - Go to DONE.
  - DONE:
    - in_ready=0, out_valid=1; out_* held stable.
    - On out_valid & out_ready: clear acc and frame count, set first-word flag, return to ACC.
    - New beats are accepted from the next cycle, not the same cycle.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. visible the cycle after that beat. Minimum frame period is 2 cycles (1 word + 1 handoff).
- Single-word frame: in_last on the first beat is legal; mode is taken from that beat.
- Zero-length frames do not exist; in_last only has meaning on an accepted beat.
- odd_mode changes mid-frame are ignored. chk_en/chk_bit are ignored on non-last beats.
- word_count saturates at 2^CNT_W-1; parity is still computed over all words.
- err_count:
  - Increments by 1 on entry to DONE when out_error=1; saturates at 2^CNT_W-1.
  - err_clr alone sets it to 0.
  - err_clr together with an increment sets it to 1 (the new error is not lost).
- in_valid while in DONE: backpressured, no state change.
- Reset mid-frame or while in DONE: partial frame and pending result are discarded; err_count is cleared.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends only on state.

Test Plan:
- Reset: assert rst mid-frame after 2 words -> in_ready=1, out_valid=0, err_count=0. A new 1-word frame 8'h01 (even) then gives out_parity=1, word_count=1.
- Even/odd sweep, WIDTH=8:
  - Frame {8'h03, 8'h01, 8'hFF}, even -> out_parity=1, word_count=3.
  - Same frame with odd_mode=1 on the first word (toggled to 0 mid-frame) -> out_parity=0.
- 3-bit equivalence, WIDTH=3: all 8 single-word frames in odd mode -> out_parity matches the original function (1 for 3'b000, 011, 101, 110; else 0).
- Checker: frame {8'hA5}, chk_en=1, chk_bit=1 (even) -> out_error=1, err_count=1. Next frame with chk_bit=0 -> out_error=0, err_count stays 1. err_clr coincident with a new error -> err_count=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, outputs stable, no words consumed.
  - Release -> result retired in 1 cycle; next word accepted the following cycle.
- Saturation, CNT_W=2:
  - 5-word frame -> word_count=3.
  - 4 error frames -> err_count=3 and stays there.
